// File: rtl/sparse_mac_encoder.sv
// Sparse-MAC skip encoder: turns a dense element stream into {value, skip}
// records. A zero run is folded into the skip field of the next record, and
// every vector ends with a record, so the decoder can rebuild the exact length.

package sparse_mac_pkg;
    localparam int VALUE_W = 16;
    localparam int INDEX_W = 16;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [INDEX_W-1:0] skip;
    } sram_data_t;
endpackage

module sparse_mac_encoder #(
    parameter int VALUE_W = sparse_mac_pkg::VALUE_W,
    parameter int INDEX_W = sparse_mac_pkg::INDEX_W,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VALUE_W-1:0]         in_value,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VALUE_W+INDEX_W-1:0] out_data,
    output logic                       out_last,
    output logic                       vec_done,
    output logic [CNT_W-1:0]           vec_len,
    output logic [CNT_W-1:0]           vec_nnz
);

    localparam logic [INDEX_W-1:0] SKIP_MAX = '1;

    logic [INDEX_W-1:0] run;
    logic [CNT_W-1:0]   elem_cnt;
    logic [CNT_W-1:0]   rec_cnt;
    logic [CNT_W-1:0]   pend_len;
    logic [CNT_W-1:0]   pend_nnz;
    logic               accept;
    logic               emit;

    // The output slot can take a new record whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;

    // Decide whether the accepted element produces a record. The last element
    // always does; a zero does only when the run would overflow the skip field.
    always_comb begin
        accept = in_valid && in_ready;
        emit   = in_last || (in_value != '0) || (run == SKIP_MAX);
    end

    // Output register: load on emit, otherwise drop valid once the old record
    // has been taken; hold everything while the writer stalls.
    // NOTE: every sequential block uses non-blocking assignments only, so all
    // registers see pre-edge values regardless of evaluation order.
    // NOTE: all registers here are control/data flops with an async clear;
    // there is no storage array that would need to stay un-reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= accept && emit;
            if (accept && emit) begin
                // A filler record is {0, SKIP_MAX}; in_value is zero and run is
                // SKIP_MAX in that case, so one expression covers every rule.
                out_data <= {in_value, run};
                out_last <= in_last;
            end
        end
    end

    // Zero-run and per-vector element/record counters; cleared at the vector end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= '0;
            elem_cnt <= '0;
            rec_cnt  <= '0;
            pend_len <= '0;
            pend_nnz <= '0;
        end else if (accept) begin
            run <= emit ? '0 : run + INDEX_W'(1);
            if (in_last) begin
                elem_cnt <= '0;
                rec_cnt  <= '0;
                pend_len <= elem_cnt + CNT_W'(1);
                pend_nnz <= rec_cnt + CNT_W'(1);
            end else begin
                elem_cnt <= elem_cnt + CNT_W'(1);
                if (emit) begin
                    rec_cnt <= rec_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Publish the statistics when the final record leaves. A new last element
    // accepted on the same edge overwrites pend_* only after they are read here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_done <= 1'b0;
            vec_len  <= '0;
            vec_nnz  <= '0;
        end else begin
            vec_done <= out_valid && out_ready && out_last;
            if (out_valid && out_ready && out_last) begin
                vec_len <= pend_len;
                vec_nnz <= pend_nnz;
            end
        end
    end

endmodule
